pw_arbiter: RTL
===============

PW_ARBITER -- requirements
Module: pw_arbiter

Interface
REQ-001 Parameter NUM_RQ, default 3, number of page-walk requesters (ITLB, AGUs); legal range 2..8.
REQ-002 Parameter RQ_W, default $clog2(NUM_RQ), width of requester ID.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 IN_req_valid  in  NUM_RQ  per-requester walk request, held until acked.
REQ-006 IN_req_addr  in  NUM_RQ*32  per-requester virtual address, slice i = bits [32*i+31:32*i].
REQ-007 IN_req_rootPPN  in  NUM_RQ*20  per-requester root page-table PPN.
REQ-008 IN_cancel  in  NUM_RQ  per-requester cancel of an outstanding walk (branch flush).
REQ-009 OUT_req_ack  out  NUM_RQ  one-cycle one-hot pulse: request i accepted.
REQ-010 OUT_pw_valid  out  1  walk command valid to walker.
REQ-011 OUT_pw_addr / OUT_pw_rootPPN  out  32 / 20  command payload.
REQ-012 IN_pw_ready  in  1  walker accepts command when OUT_pw_valid && IN_pw_ready.
REQ-013 IN_pw_resValid  in  1  walker result valid (single cycle).
REQ-014 IN_pw_res  in  27  result {ppn[19:0], rwx[2:0], user, isSuper, pageFault, accessFault}.
REQ-015 OUT_res_valid  out  NUM_RQ  one-hot result delivery to owner.
REQ-016 OUT_res  out  27  registered copy of IN_pw_res.
REQ-017 OUT_busy / OUT_rqID  out  1 / RQ_W  walk in progress and owning requester.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT; exactly one walk outstanding at any time.
REQ-019 IDLE: if any IN_req_valid, grant one by round-robin, latch addr/rootPPN/ID, go ISSUE next cycle; else stay IDLE.
REQ-020 Round-robin: search starts at pointer ptr, wraps modulo NUM_RQ; after grant ptr = granted ID + 1 (wrap NUM_RQ-1 -> 0).
REQ-021 OUT_req_ack[g] pulses in the first ISSUE cycle (one cycle after grant); requester deasserts valid next cycle.
REQ-022 ISSUE: OUT_pw_valid = 1 with latched payload, held stable until IN_pw_ready; on handshake go WAIT.
REQ-023 WAIT: on IN_pw_resValid go IDLE; OUT_res_valid[owner] = 1 and OUT_res = IN_pw_res exactly one cycle later, unless dropped.
REQ-024 OUT_busy = 1 in ISSUE and WAIT; OUT_rqID = owner in those states, don't-care in IDLE.
REQ-025 IN_cancel[owner] in ISSUE before handshake: return to IDLE next cycle, no command issued.
REQ-026 IN_cancel[owner] in WAIT, or same cycle as IN_pw_resValid: set drop flag; result consumed, OUT_res_valid stays 0.
REQ-027 IN_cancel for non-owner IDs: ignored; IN_cancel in IDLE: ignored.
REQ-028 IN_pw_resValid outside WAIT: ignored, no output.
REQ-029 Result and new request in same cycle: result handled, new grant evaluated in following IDLE cycle (one-cycle bubble).
REQ-030 Request valid in ISSUE/WAIT from non-owners: held pending, no ack until granted.

Reset
REQ-031 On rst: state IDLE, ptr = 0, drop = 0, OUT_pw_valid = 0, OUT_req_ack = 0, OUT_res_valid = 0, OUT_busy = 0.
REQ-032 rst mid-walk abandons the walk; a later IN_pw_resValid is ignored (REQ-028).
REQ-033 Payload outputs (addr, rootPPN, res, rqID) are don't-care while their valids are 0.

Verification
REQ-034 Single req: req 1, addr 0x8000_1234, ready=1 -> ack[1] at t+1, pw_valid t+1, result at t+5 -> res_valid = 3'b010 at t+6 with matching payload.
REQ-035 All three req simultaneously after reset -> grant order 0,1,2; then req0+req2 -> grant 0 then 2 (ptr wrap verified).
REQ-036 Backpressure: ready=0 for 4 cycles -> pw_valid held, payload stable, ack exactly once.
REQ-037 Cancel in WAIT for owner 2 -> result accepted, res_valid stays 0, next request granted normally.
REQ-038 rst asserted in WAIT, then resValid -> all outputs 0, no res_valid; fresh request after reset granted to requester 0 first.

Source files
------------

// File: rtl/pw_arbiter.sv
// pw_arbiter
// Round-robin arbiter that lets several page-walk requesters (ITLB, AGUs)
// share a single page-table walker, with exactly one walk outstanding.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   IN_req_valid      per-requester walk request, held until acked
//   IN_req_addr       per-requester virtual address (32 bits per slice)
//   IN_req_rootPPN    per-requester root page-table PPN (20 bits per slice)
//   IN_cancel         per-requester cancel of its outstanding walk
//   OUT_req_ack       one-hot, one-cycle acceptance pulse
//   OUT_pw_valid      walk command valid towards the walker
//   OUT_pw_addr       walk command virtual address
//   OUT_pw_rootPPN    walk command root PPN
//   IN_pw_ready       walker accepts the command
//   IN_pw_resValid    walker result strobe
//   IN_pw_res         walker result
//   OUT_res_valid     one-hot result delivery to the owning requester
//   OUT_res           registered walker result
//   OUT_busy          walk in progress
//   OUT_rqID          owner of the walk in progress
module pw_arbiter #(
  parameter int NUM_RQ = 3,
  parameter int RQ_W   = $clog2(NUM_RQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RQ-1:0]    IN_req_valid,
  input  logic [NUM_RQ*32-1:0] IN_req_addr,
  input  logic [NUM_RQ*20-1:0] IN_req_rootPPN,
  input  logic [NUM_RQ-1:0]    IN_cancel,
  output logic [NUM_RQ-1:0]    OUT_req_ack,
  output logic                 OUT_pw_valid,
  output logic [31:0]          OUT_pw_addr,
  output logic [19:0]          OUT_pw_rootPPN,
  input  logic                 IN_pw_ready,
  input  logic                 IN_pw_resValid,
  input  logic [26:0]          IN_pw_res,
  output logic [NUM_RQ-1:0]    OUT_res_valid,
  output logic [26:0]          OUT_res,
  output logic                 OUT_busy,
  output logic [RQ_W-1:0]      OUT_rqID
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [RQ_W-1:0]   ptr_q, ptr_d;
  logic [RQ_W-1:0]   owner_q, owner_d;
  logic [31:0]       addr_q, addr_d;
  logic [19:0]       root_q, root_d;
  logic [NUM_RQ-1:0] ack_q, ack_d;
  logic [NUM_RQ-1:0] resValid_q, resValid_d;
  logic [26:0]       res_q, res_d;
  logic              drop_q, drop_d;

  logic              grantFound;
  logic [RQ_W-1:0]   grantId;
  logic              ownerCancel;

  // Round-robin search starting at ptr_q; iterating from the farthest offset
  // down lets the closest valid requester overwrite earlier matches.
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    for (int i = NUM_RQ - 1; i >= 0; i--) begin
      if (IN_req_valid[(int'(ptr_q) + i) % NUM_RQ]) begin
        grantFound = 1'b1;
        grantId    = RQ_W'((int'(ptr_q) + i) % NUM_RQ);
      end
    end
  end

  assign ownerCancel = IN_cancel[owner_q];

  // Next-state logic. A cancel from the owner during ISSUE suppresses the
  // command in that same cycle so the walker can never accept it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    root_d     = root_q;
    ack_d      = '0;
    resValid_d = '0;
    res_d      = res_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        if (grantFound) begin
          state_d        = ISSUE;
          owner_d        = grantId;
          addr_d         = IN_req_addr[32*grantId +: 32];
          root_d         = IN_req_rootPPN[20*grantId +: 20];
          ack_d[grantId] = 1'b1;
          ptr_d          = (grantId == RQ_W'(NUM_RQ - 1)) ? '0 : grantId + 1'b1;
          drop_d         = 1'b0;
        end
      end
      ISSUE: begin
        if (ownerCancel) begin
          state_d = IDLE;
        end else if (IN_pw_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (IN_pw_resValid) begin
          state_d = IDLE;
          res_d   = IN_pw_res;
          drop_d  = 1'b0;
          if (!(drop_q || ownerCancel)) begin
            resValid_d[owner_q] = 1'b1;
          end
        end else if (ownerCancel) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      root_q     <= '0;
      ack_q      <= '0;
      resValid_q <= '0;
      res_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      root_q     <= root_d;
      ack_q      <= ack_d;
      resValid_q <= resValid_d;
      res_q      <= res_d;
      drop_q     <= drop_d;
    end
  end

  assign OUT_req_ack    = ack_q;
  assign OUT_pw_valid   = (state_q == ISSUE) && !ownerCancel;
  assign OUT_pw_addr    = addr_q;
  assign OUT_pw_rootPPN = root_q;
  assign OUT_res_valid  = resValid_q;
  assign OUT_res        = res_q;
  assign OUT_busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign OUT_rqID       = owner_q;

endmodule
